sonar_ping_ctrl: RTL

Measurement sequencer for one sonar ping, placed beside the receive chain. It drives the ultrasonic transmit tone and holds the receive chain's `mclear` during the burst and a blanking window. It then times the echo by counting `ce_pcm` ticks until the receive chain's `cmp` output rises, or until a timeout. The block consumes `cmp` and produces `mclear` for the receive chain.

---
 rtl/sonar_pkg.sv | 22 ++
 rtl/sonar_tone_gen.sv | 61 ++++++
 rtl/sonar_ping_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/sonar_pkg.sv
// Shared types and widths for the sonar ping sequencer and the receive chain beside it.
package sonar_pkg;

    localparam int CNT_W_DEF  = 24;
    localparam int HALF_W_DEF = 16;
    localparam int PULSE_W    = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_BURST,
        S_BLANK,
        S_LISTEN,
        S_DONE
    } ping_state_t;

    // The receive chain is held cleared while the transmitter is active or ringing.
    function automatic logic mclear_state(input ping_state_t s);
        return (s == S_CLEAR) || (s == S_BURST) || (s == S_BLANK);
    endfunction

endpackage

// File: rtl/sonar_tone_gen.sv
// Ultrasonic tone generator: square wave of 2*pulses levels, each i_half clocks long.
module sonar_tone_gen
    import sonar_pkg::*;
#(
    parameter int HALF_W = HALF_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_en,
    input  logic [HALF_W-1:0]  i_half,
    input  logic [PULSE_W-1:0] i_pulses,
    output logic               o_tx,
    output logic               o_finished
);

    logic               r_run;
    logic [HALF_W-1:0]  r_cnt;
    logic [PULSE_W:0]   r_tog;
    logic [HALF_W-1:0]  w_half_m1;
    logic [PULSE_W:0]   w_tog_nxt;
    logic               w_tc;
    logic               w_last;

    // A half-period of 0 behaves as 1.
    assign w_half_m1  = (i_half == '0) ? '0 : i_half - 1'b1;
    assign w_tc       = (r_cnt >= w_half_m1);
    assign w_tog_nxt  = r_tog + 1'b1;
    assign w_last     = (w_tog_nxt >= {i_pulses, 1'b0});
    assign o_finished = r_run && w_tc && w_last;

    // i_en rises on the edge entering the burst, so the first high level starts there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run <= 1'b0;
            r_cnt <= '0;
            r_tog <= '0;
            o_tx  <= 1'b0;
        end else if (!i_en) begin
            r_run <= 1'b0;
            r_cnt <= '0;
            r_tog <= '0;
            o_tx  <= 1'b0;
        end else if (!r_run) begin
            r_run <= 1'b1;
            r_cnt <= '0;
            r_tog <= '0;
            o_tx  <= 1'b1;
        end else if (w_tc) begin
            r_cnt <= '0;
            if (w_last) begin
                o_tx <= 1'b0;
            end else begin
                r_tog <= w_tog_nxt;
                o_tx  <= ~o_tx;
            end
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sonar_ping_ctrl.sv
// One-ping sonar sequencer: clear, tone burst, blanking, then echo timing on ce_pcm ticks.
module sonar_ping_ctrl
    import sonar_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int HALF_W = HALF_W_DEF
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [HALF_W-1:0]  burst_half_i,
    input  logic [PULSE_W-1:0] burst_pulses_i,
    input  logic [CNT_W-1:0]   blank_i,
    input  logic [CNT_W-1:0]   timeout_i,
    input  logic               ce_pcm,
    input  logic               cmp_i,
    output logic               tx_o,
    output logic               mclear,
    output logic               busy_o,
    output logic               done_o,
    output logic               echo_valid_o,
    output logic               timeout_o,
    output logic [CNT_W-1:0]   echo_time_o
);

    ping_state_t        r_state;
    ping_state_t        w_state_nxt;
    logic [HALF_W-1:0]  r_half;
    logic [PULSE_W-1:0] r_pulses;
    logic [CNT_W-1:0]   r_blank;
    logic [CNT_W-1:0]   r_timeout;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [CNT_W-1:0]   w_echo_time;
    logic               w_accept;
    logic               w_echo;
    logic               w_tmo;
    logic               w_tone_en;
    logic               w_tone_fin;

    assign w_cnt_inc   = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;
    // An echo seen on a tick cycle includes that tick.
    assign w_echo_time = ce_pcm ? w_cnt_inc : r_cnt;
    assign w_accept    = (r_state == S_IDLE) && (w_state_nxt == S_CLEAR);
    assign w_tone_en   = (w_state_nxt == S_BURST);

    sonar_tone_gen #(
        .HALF_W(HALF_W)
    ) u_tone (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .i_en      (w_tone_en),
        .i_half    (r_half),
        .i_pulses  (r_pulses),
        .o_tx      (tx_o),
        .o_finished(w_tone_fin)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_echo      = 1'b0;
        w_tmo       = 1'b0;
        if (abort_i) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (start_i) w_state_nxt = S_CLEAR;
                S_CLEAR:  w_state_nxt = (r_pulses == '0) ? S_BLANK : S_BURST;
                S_BURST:  if (w_tone_fin) w_state_nxt = S_BLANK;
                S_BLANK:  if ((r_blank == '0) || (ce_pcm && (w_cnt_inc >= r_blank)))
                              w_state_nxt = S_LISTEN;
                S_LISTEN: begin
                    if (cmp_i) begin
                        w_echo      = 1'b1;
                        w_state_nxt = S_DONE;
                    end else if (ce_pcm && (w_cnt_inc >= r_timeout)) begin
                        w_tmo       = 1'b1;
                        w_state_nxt = S_DONE;
                    end
                end
                S_DONE:   w_state_nxt = S_IDLE;
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            busy_o       <= 1'b0;
            mclear       <= 1'b0;
            done_o       <= 1'b0;
            echo_valid_o <= 1'b0;
            timeout_o    <= 1'b0;
            echo_time_o  <= '0;
            r_cnt        <= '0;
            r_half       <= '0;
            r_pulses     <= '0;
            r_blank      <= '0;
            r_timeout    <= '0;
        end else begin
            busy_o <= (w_state_nxt != S_IDLE);
            mclear <= mclear_state(w_state_nxt);
            done_o <= (w_state_nxt == S_DONE);

            if (r_state != w_state_nxt)
                r_cnt <= '0;
            else if (ce_pcm && ((r_state == S_BLANK) || (r_state == S_LISTEN)))
                r_cnt <= w_cnt_inc;

            if (w_accept) begin
                r_half       <= burst_half_i;
                r_pulses     <= burst_pulses_i;
                r_blank      <= blank_i;
                r_timeout    <= timeout_i;
                echo_valid_o <= 1'b0;
                timeout_o    <= 1'b0;
                echo_time_o  <= '0;
            end

            if (w_echo) begin
                echo_valid_o <= 1'b1;
                echo_time_o  <= w_echo_time;
            end
            if (w_tmo) timeout_o <= 1'b1;
        end
    end

endmodule
